if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'hBFC0_0000, giving the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port stall, input, StallBus (6) bits: pipeline stall vector, where bit 0 = PC hold and bit 1 = IF/ID register hold.
REQ-005 SHALL have port br_bus, input, 33 bits: {br_e, br_addr[31:0]}, the redirect request from decode.
REQ-006 SHALL have port if_to_id_bus, output, 33 bits: {ce, pc[31:0]}, registered into decode.
REQ-007 SHALL have port inst_sram_en, output, 1 bit: instruction memory read enable.
REQ-008 SHALL have port inst_sram_wen, output, 4 bits: instruction memory write enables, always 4'b0000.
REQ-009 SHALL have port inst_sram_addr, output, 32 bits: fetch address.
REQ-010 SHALL have port inst_sram_wdata, output, 32 bits: always 32'h0.

Function
REQ-011 SHALL hold registers pc_reg[31:0], ce_reg, pend_v, pend_addr[31:0], and a state register with states RESET, RUN and HOLD.
REQ-012 SHALL drive outputs as: inst_sram_en=ce_reg; inst_sram_addr=pc_reg; if_to_id_bus={ce_reg,pc_reg}. All outputs are combinational from registers only.
REQ-013 SHALL form next_pc by priority: br_e -> br_addr; else pend_v -> pend_addr; else pc_reg+4. The +4 is modulo 2^32, so 32'hFFFF_FFFC+4 wraps to 32'h0.
REQ-014 In RESET with rst high, SHALL on the next edge load pc_reg=RESET_PC and ce_reg=1, and enter RUN; the first fetch is RESET_PC exactly one cycle after reset release.
REQ-015 In RUN with stall[0]==NoStop, SHALL load pc_reg=next_pc and clear pend_v each cycle.
REQ-016 In RUN with stall[0]==Stop, SHALL hold pc_reg and ce_reg and enter HOLD; if br_e is high in that cycle, SHALL set pend_v=1 and pend_addr=br_addr.
REQ-017 In HOLD, a br_e arriving while pend_v=0 SHALL be latched into pend_v/pend_addr; while pend_v=1, a later br_e SHALL overwrite pend_addr (youngest redirect wins).
REQ-018 In HOLD, when stall[0] returns to NoStop, SHALL load pc_reg=next_pc, clear pend_v and return to RUN.
REQ-019 Redirect SHALL take effect one fetch after the delay slot: when decode holds a branch at pc X, pc_reg=X+4 is on the bus, and the following fetch is br_addr.
REQ-020 br_e and stall release in the same cycle SHALL use br_addr; no branch is ever dropped or applied twice.
REQ-021 SHALL not check alignment; br_addr[1:0] passes through unchanged.

Reset
REQ-022 When rst=0 at a rising edge, SHALL set pc_reg=RESET_PC-4, ce_reg=0, pend_v=0, pend_addr=0, and state=RESET, regardless of state or stall.
REQ-023 During reset and until the first RUN cycle, SHALL drive inst_sram_en=0 and if_to_id_bus=33'h0_BFBF_FFFC (ce=0), so decode treats it as a bubble.
REQ-024 Reset asserted mid-HOLD SHALL discard any pending redirect.

Structure
REQ-025 SHALL take StallBus, IF_TO_ID_WD (33), BR_WD (33), and Stop/NoStop from the shared defines header, with no local redefinition.
REQ-026 SHALL place the state encoding (2 bits: RESET/RUN/HOLD) locally in the module.
REQ-027 SHALL be implemented as a single module with no sub-module; the redirect latch is too small to justify one.

Verification
REQ-028 Reset release: rst=0 for 3 cycles, then 1 -> cycle+1 ce=1, addr=BFC00000; cycle+2 BFC00004; cycle+3 BFC00008.
REQ-029 Plain branch: br_bus={1,32'hBFC00100} for one cycle while pc_reg=BFC00008 -> next addr BFC00100, then BFC00104.
REQ-030 Branch during stall: stall[0]=Stop for 3 cycles, br_e pulsed in cycle 1 with 32'h80000040 -> pc_reg frozen for 3 cycles, then 80000040; pend_v cleared afterwards.
REQ-031 Double redirect in HOLD: br_addr 0x100 then 0x200 while stalled -> after release, fetch 0x200 exactly once.
REQ-032 Wrap: force pc_reg=FFFFFFFC with no branch -> next addr 00000000.
REQ-033 Mid-stall reset: rst=0 while pend_v=1 -> first fetch after release is BFC00000, not the pending address.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared pipeline widths and stall encodings.
// Imported by the fetch stage and its neighbours.
package if_stage_pkg;

  localparam int StallBus    = 6;
  localparam int IF_TO_ID_WD = 33;
  localparam int BR_WD       = 33;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

endpackage

// File: rtl/if_stage.sv
// Instruction fetch stage: PC sequencing,
// stall hold and deferred branch redirect.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [StallBus-1:0]    stall,
  input  logic [BR_WD-1:0]       br_bus,
  output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
  output logic                   inst_sram_en,
  output logic [3:0]             inst_sram_wen,
  output logic [31:0]            inst_sram_addr,
  output logic [31:0]            inst_sram_wdata
);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_RUN   = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_ce;
  logic        r_pend_v;
  logic [31:0] r_pend_addr;

  state_t      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic        w_ce_nxt;
  logic        w_pend_v_nxt;
  logic [31:0] w_pend_addr_nxt;

  logic        w_br_e;
  logic [31:0] w_br_addr;
  logic [31:0] w_next_pc;
  logic        w_hold;
  logic        w_unused;

  assign w_br_e    = br_bus[32];
  assign w_br_addr = br_bus[31:0];
  assign w_hold    = (stall[0] == Stop);

  // IF/ID hold is applied downstream.
  assign w_unused = ^stall[StallBus-1:1];

  // Redirect beats a deferred redirect,
  // which beats sequential fetch.
  assign w_next_pc = w_br_e   ? w_br_addr   :
                     r_pend_v ? r_pend_addr :
                                r_pc + 32'd4;

  // Next-state and next-register selection.
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_ce_nxt        = r_ce;
    w_pend_v_nxt    = r_pend_v;
    w_pend_addr_nxt = r_pend_addr;
    unique case (r_state)
      S_RESET: begin
        w_pc_nxt    = RESET_PC;
        w_ce_nxt    = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_RUN, S_HOLD: begin
        if (!w_hold) begin
          w_pc_nxt     = w_next_pc;
          w_pend_v_nxt = 1'b0;
          w_state_nxt  = S_RUN;
        end else begin
          w_state_nxt = S_HOLD;
          if (w_br_e) begin
            w_pend_v_nxt    = 1'b1;
            w_pend_addr_nxt = w_br_addr;
          end
        end
      end
      default: begin
        w_state_nxt = S_RESET;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_RESET;
      r_pc        <= RESET_PC - 32'd4;
      r_ce        <= 1'b0;
      r_pend_v    <= 1'b0;
      r_pend_addr <= 32'h0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_ce        <= w_ce_nxt;
      r_pend_v    <= w_pend_v_nxt;
      r_pend_addr <= w_pend_addr_nxt;
    end
  end

  assign inst_sram_en    = r_ce;
  assign inst_sram_addr  = r_pc;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_wdata = 32'h0;
  assign if_to_id_bus    = {r_ce, r_pc};

endmodule

// File: tb/tb_if_stage.sv
// Fetch stage bench: directed redirect/stall
// cases plus random traffic against a model.
module tb_if_stage;
  import if_stage_pkg::*;

  localparam logic [31:0] RPC = 32'hBFC0_0000;

  logic                   clk;
  logic                   rst;
  logic [StallBus-1:0]    stall;
  logic [BR_WD-1:0]       br_bus;
  logic [IF_TO_ID_WD-1:0] if_to_id_bus;
  logic                   inst_sram_en;
  logic [3:0]             inst_sram_wen;
  logic [31:0]            inst_sram_addr;
  logic [31:0]            inst_sram_wdata;

  int checks = 0;
  int errors = 0;

  if_stage #(.RESET_PC(RPC)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .br_bus         (br_bus),
    .if_to_id_bus   (if_to_id_bus),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_wen  (inst_sram_wen),
    .inst_sram_addr (inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: "started" means the
  // first post-reset fetch has been issued;
  // a stalled fetch only remembers the
  // youngest redirect seen.
  bit          m_known   = 0;
  bit          m_started = 0;
  logic [31:0] m_pc;
  bit          m_ce;
  bit          m_pend_v;
  logic [31:0] m_pend;

  initial forever begin
    @(posedge clk);
    if (!rst) begin
      m_known   = 1;
      m_started = 0;
      m_pc      = RPC - 32'd4;
      m_ce      = 0;
      m_pend_v  = 0;
      m_pend    = 32'h0;
    end else if (!m_known) begin
    end else if (!m_started) begin
      m_started = 1;
      m_pc      = RPC;
      m_ce      = 1;
    end else if (stall[0]) begin
      if (br_bus[32]) begin
        m_pend_v = 1;
        m_pend   = br_bus[31:0];
      end
    end else begin
      if (br_bus[32])    m_pc = br_bus[31:0];
      else if (m_pend_v) m_pc = m_pend;
      else               m_pc = m_pc + 32'd4;
      m_pend_v = 0;
    end
  end

  // Every-cycle compare against the model.
  initial forever begin
    @(negedge clk);
    if (m_known) begin
      checks++;
      if (inst_sram_addr  !== m_pc ||
          inst_sram_en    !== m_ce ||
          if_to_id_bus    !== {m_ce, m_pc} ||
          inst_sram_wen   !== 4'b0000 ||
          inst_sram_wdata !== 32'h0) begin
        errors++;
        $display("FAIL model t=%0t got en=%b addr=%h bus=%h wen=%h wd=%h want en=%b addr=%h",
                 $time, inst_sram_en, inst_sram_addr,
                 if_to_id_bus, inst_sram_wen,
                 inst_sram_wdata, m_ce, m_pc);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] exp);
    checks++;
    if (inst_sram_addr !== exp ||
        inst_sram_en !== 1'b1) begin
      errors++;
      $display("FAIL %s got en=%b addr=%h want en=1 addr=%h",
               nm, inst_sram_en, inst_sram_addr, exp);
    end
  endtask

  task automatic chk_bubble(input string nm);
    checks++;
    if (if_to_id_bus !== 33'h0_BFBF_FFFC ||
        inst_sram_en !== 1'b0) begin
      errors++;
      $display("FAIL %s got bus=%h en=%b want bus=0bfbffffc en=0",
               nm, if_to_id_bus, inst_sram_en);
    end
  endtask

  function automatic logic [32:0] br(
    input logic [31:0] a);
    return {1'b1, a};
  endfunction

  initial begin
    rst    = 1'b0;
    stall  = '0;
    br_bus = '0;
    tick(); tick(); tick();
    chk_bubble("rst_bubble");
    rst = 1'b1;
    tick(); chk("rel_1", 32'hBFC0_0000);
    tick(); chk("rel_2", 32'hBFC0_0004);
    tick(); chk("rel_3", 32'hBFC0_0008);
    br_bus = br(32'hBFC0_0100);
    tick(); chk("br_tgt", 32'hBFC0_0100);
    br_bus = '0;
    tick(); chk("br_seq", 32'hBFC0_0104);
    stall[0] = Stop;
    br_bus = br(32'h8000_0040);
    tick(); chk("hold_1", 32'hBFC0_0104);
    br_bus = '0;
    tick(); chk("hold_2", 32'hBFC0_0104);
    tick(); chk("hold_3", 32'hBFC0_0104);
    stall[0] = NoStop;
    tick(); chk("pend_tgt", 32'h8000_0040);
    tick(); chk("pend_clr", 32'h8000_0044);
    stall[0] = Stop;
    br_bus = br(32'h0000_0100);
    tick(); chk("dbl_h1", 32'h8000_0044);
    br_bus = br(32'h0000_0200);
    tick(); chk("dbl_h2", 32'h8000_0044);
    br_bus = '0;
    tick(); chk("dbl_h3", 32'h8000_0044);
    stall[0] = NoStop;
    tick(); chk("dbl_tgt", 32'h0000_0200);
    tick(); chk("dbl_once", 32'h0000_0204);
    stall[0] = Stop;
    br_bus = br(32'h0000_0300);
    tick(); chk("same_h", 32'h0000_0204);
    br_bus = br(32'h0000_0400);
    stall[0] = NoStop;
    tick(); chk("same_tgt", 32'h0000_0400);
    br_bus = '0;
    tick(); chk("same_seq", 32'h0000_0404);
    br_bus = br(32'h0000_0013);
    tick(); chk("unal_tgt", 32'h0000_0013);
    br_bus = '0;
    tick(); chk("unal_seq", 32'h0000_0017);
    br_bus = br(32'hFFFF_FFFC);
    tick(); chk("wrap_top", 32'hFFFF_FFFC);
    br_bus = '0;
    tick(); chk("wrap_zero", 32'h0000_0000);
    stall[0] = Stop;
    br_bus = br(32'h0000_0500);
    tick(); chk("mrst_h", 32'h0000_0000);
    br_bus = '0;
    rst = 1'b0;
    tick(); chk_bubble("mrst_b1");
    tick(); chk_bubble("mrst_b2");
    rst = 1'b1;
    stall[0] = NoStop;
    tick(); chk("mrst_1", 32'hBFC0_0000);
    tick(); chk("mrst_2", 32'hBFC0_0004);

    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 59) != 0);
      stall = StallBus'($urandom);
      stall[0] = ($urandom_range(0, 2) == 0);
      br_bus[32] = ($urandom_range(0, 3) == 0);
      br_bus[31:0] =
        ($urandom_range(0, 7) == 0) ?
          32'hFFFF_FFFC : $urandom;
      tick();
    end
    rst    = 1'b1;
    stall  = '0;
    br_bus = '0;
    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
